mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 24 ++
 rtl/mem_arbiter_rr_arb2.sv | 21 ++
 rtl/mem_arbiter.sv | 167 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the instruction/data memory arbiter.
package mem_arb_pkg;

  // Default depth of the attached memory, in 32-bit words.
  localparam int unsigned MEM_WORDS_DEFAULT = 32'd128;

  // Port identifiers, also used as the encoding of the last-grant flop.
  localparam logic PORT_FETCH = 1'b0;
  localparam logic PORT_DATA  = 1'b1;

  // Arbiter sequencing states.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } arb_state_e;

  // True when a word address falls inside the attached memory.
  function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned words);
    return (addr < words);
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin chooser: bit 0 is the fetch port, bit 1 the data port.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  // Lone requester wins outright; on a tie the port not served last wins.
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (last == PORT_DATA) ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one synchronous single-port memory between an instruction-fetch
// port and a data load/store port. Each in-range access walks
// IDLE -> ACCESS -> CAPTURE -> DONE; out-of-range accesses skip to DONE.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned MEM_WORDS = MEM_WORDS_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ready,
  output logic [31:0] i_rdata,
  output logic        i_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ready,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        mem_r_wbar,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  arb_state_e  state_q, state_d;
  logic        last_q, last_d;        // port of the current/most recent grant
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        mem_r_wbar_q, mem_r_wbar_d;
  logic        i_ready_q, i_ready_d;
  logic        d_ready_q, d_ready_d;
  logic        i_err_q, i_err_d;
  logic        d_err_q, d_err_d;
  logic [31:0] i_rdata_q, i_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;

  logic [1:0]  req_s;
  logic [1:0]  grant_s;
  logic        gnt_any_s;
  logic        gnt_port_s;
  logic [31:0] gnt_addr_s;
  logic [31:0] gnt_wdata_s;
  logic        gnt_we_s;
  logic        gnt_ok_s;

  assign req_s = {d_req, i_req};

  rr_arb2 u_rr_arb2 (
    .req   (req_s),
    .last  (last_q),
    .grant (grant_s)
  );

  // Mux the winning port's request fields; fetches never write.
  assign gnt_any_s   = |grant_s;
  assign gnt_port_s  = grant_s[1] ? PORT_DATA : PORT_FETCH;
  assign gnt_addr_s  = (gnt_port_s == PORT_DATA) ? d_addr : i_addr;
  assign gnt_we_s    = (gnt_port_s == PORT_DATA) ? d_we : 1'b0;
  assign gnt_wdata_s = (gnt_port_s == PORT_DATA) ? d_wdata : 32'h0000_0000;
  assign gnt_ok_s    = addr_in_range(gnt_addr_s, MEM_WORDS);

  // Next-state and next-output logic; memory is read unless a store is in ACCESS.
  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_r_wbar_d = 1'b1;
    i_ready_d    = 1'b0;
    d_ready_d    = 1'b0;
    i_err_d      = 1'b0;
    d_err_d      = 1'b0;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt_any_s) begin
          last_d = gnt_port_s;
          if (gnt_ok_s) begin
            state_d      = ST_ACCESS;
            mem_addr_d   = gnt_addr_s;
            mem_wdata_d  = gnt_wdata_s;
            mem_r_wbar_d = ~gnt_we_s;
          end else begin
            // Out of range: complete with an error, memory never touched.
            state_d = ST_DONE;
            if (gnt_port_s == PORT_DATA) begin
              d_ready_d = 1'b1;
              d_err_d   = 1'b1;
              d_rdata_d = 32'h0000_0000;
            end else begin
              i_ready_d = 1'b1;
              i_err_d   = 1'b1;
              i_rdata_d = 32'h0000_0000;
            end
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        // Memory data registered at the end of ACCESS is valid now.
        state_d = ST_DONE;
        if (last_q == PORT_DATA) begin
          d_rdata_d = mem_rdata;
          d_ready_d = 1'b1;
        end else begin
          i_rdata_d = mem_rdata;
          i_ready_d = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset abandons any access in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_q       <= PORT_DATA;
      mem_addr_q   <= 32'h0000_0000;
      mem_wdata_q  <= 32'h0000_0000;
      mem_r_wbar_q <= 1'b1;
      i_ready_q    <= 1'b0;
      d_ready_q    <= 1'b0;
      i_err_q      <= 1'b0;
      d_err_q      <= 1'b0;
      i_rdata_q    <= 32'h0000_0000;
      d_rdata_q    <= 32'h0000_0000;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_r_wbar_q <= mem_r_wbar_d;
      i_ready_q    <= i_ready_d;
      d_ready_q    <= d_ready_d;
      i_err_q      <= i_err_d;
      d_err_q      <= d_err_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_r_wbar = mem_r_wbar_q;
  assign i_ready    = i_ready_q;
  assign d_ready    = d_ready_q;
  assign i_err      = i_err_q;
  assign d_err      = d_err_q;
  assign i_rdata    = i_rdata_q;
  assign d_rdata    = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a behavioural synchronous memory.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, d_req, d_we;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic        i_ready, d_ready, i_err, d_err;
  logic [31:0] i_rdata, d_rdata;
  logic        mem_r_wbar;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int wr_low = 0;

  typedef struct packed {
    logic [31:0] rdata;
    logic        chk_rdata;
    logic        err;
    logic [31:0] cyc;
  } exp_t;

  exp_t i_q[$];
  exp_t d_q[$];

  logic [31:0] mem [0:127];
  logic        mem_loaded = 1'b0;

  always #5 clk = ~clk;

  mem_arbiter #(.MEM_WORDS(128)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rdata(d_rdata), .d_err(d_err),
    .mem_r_wbar(mem_r_wbar), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Memory model: preloaded word k = 0x1000_0000 + k, word 0 = 0x00221820; read-first.
  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int k = 0; k < 128; k++) mem[k] <= 32'h1000_0000 + k;
      mem[0] <= 32'h0022_1820;
      mem_loaded <= 1'b1;
    end else begin
      if (!mem_r_wbar && mem_addr < 32'd128) mem[mem_addr[6:0]] <= mem_wdata;
    end
    mem_rdata <= mem[mem_addr[6:0]];
  end

  // Cycle count and count of edges at which the memory saw a write.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!mem_r_wbar) wr_low <= wr_low + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every completion pops the expectation of its port.
  always @(negedge clk) begin
    exp_t e;
    if (i_ready === 1'b1) begin
      if (i_q.size() == 0) begin
        total++; bad++;
        $display("FAIL i_unexpected: got i_ready=1 want no completion (cycle %0d)", cyc);
      end else begin
        e = i_q.pop_front();
        chk("i_cycle", cyc, e.cyc);
        if (e.chk_rdata) chk("i_rdata", i_rdata, e.rdata);
        chk("i_err", {31'd0, i_err}, {31'd0, e.err});
      end
    end
    if (d_ready === 1'b1) begin
      if (d_q.size() == 0) begin
        total++; bad++;
        $display("FAIL d_unexpected: got d_ready=1 want no completion (cycle %0d)", cyc);
      end else begin
        e = d_q.pop_front();
        chk("d_cycle", cyc, e.cyc);
        if (e.chk_rdata) chk("d_rdata", d_rdata, e.rdata);
        chk("d_err", {31'd0, d_err}, {31'd0, e.err});
      end
    end
  end

  function automatic exp_t mk(input logic [31:0] rdata, input logic chk_rd,
                              input logic err, input int at);
    exp_t e;
    e.rdata = rdata; e.chk_rdata = chk_rd; e.err = err; e.cyc = at;
    return e;
  endfunction

  task automatic wait_ready(input logic port);
    bit seen = 1'b0;
    for (int k = 0; k < 16 && !seen; k++) begin
      @(negedge clk);
      seen = port ? d_ready : i_ready;
    end
    if (!seen) begin
      total++; bad++;
      $display("FAIL %s_timeout: got no ready want ready within 16 cycles", port ? "d" : "i");
    end
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  // Fetch from idle; lat is cycles from the request edge to the visible ready.
  task automatic fetch(input logic [31:0] addr, input logic [31:0] exp, input logic err, input int lat);
    @(negedge clk);
    i_addr = addr; i_req = 1'b1;
    i_q.push_back(mk(exp, 1'b1, err, cyc + lat));
    wait_ready(1'b0);
    i_req = 1'b0;
  endtask

  task automatic data(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp, input logic chk_rd, input logic err, input int lat);
    @(negedge clk);
    d_we = we; d_addr = addr; d_wdata = wdata; d_req = 1'b1;
    d_q.push_back(mk(exp, chk_rd, err, cyc + lat));
    wait_ready(1'b1);
    d_req = 1'b0;
  endtask

  initial begin
    int n;
    int wr_snap;
    rst = 1'b1; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    i_addr = 32'd0; d_addr = 32'd0; d_wdata = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_i_ready", {31'd0, i_ready}, 32'd0);
    chk("rst_d_ready", {31'd0, d_ready}, 32'd0);
    chk("rst_i_err", {31'd0, i_err}, 32'd0);
    chk("rst_d_err", {31'd0, d_err}, 32'd0);
    chk("rst_i_rdata", i_rdata, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    chk("rst_r_wbar", {31'd0, mem_r_wbar}, 32'd1);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    rst = 1'b0;

    // Lone fetch, then store/load round trip.
    fetch(32'd0, 32'h0022_1820, 1'b0, 3);
    data(1'b1, 32'd20, 32'hDEAD_BEEF, 32'd0, 1'b0, 1'b0, 3);
    chk("mem20_after_store", mem[20], 32'hDEAD_BEEF);
    data(1'b0, 32'd20, 32'd0, 32'hDEAD_BEEF, 1'b1, 1'b0, 3);

    // Out-of-range store: error, rdata 0, one-cycle latency, no write.
    wr_snap = wr_low;
    data(1'b1, 32'd200, 32'h1234_5678, 32'd0, 1'b1, 1'b1, 1);
    chk("oor_no_write", wr_low, wr_snap);
    chk("mem72_unchanged", mem[72], 32'h1000_0048);

    // Address boundary: last legal word, then first illegal word.
    fetch(32'd127, 32'h1000_007F, 1'b0, 3);
    fetch(32'd128, 32'd0, 1'b1, 1);

    // Both requests held out of reset: I, D, I, D every 4 cycles.
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; i_addr = 32'd4; d_addr = 32'd8; d_we = 1'b0; i_req = 1'b1; d_req = 1'b1;
    n = cyc;
    i_q.push_back(mk(32'h1000_0004, 1'b1, 1'b0, n + 3));
    d_q.push_back(mk(32'h1000_0008, 1'b1, 1'b0, n + 7));
    i_q.push_back(mk(32'h1000_0004, 1'b1, 1'b0, n + 11));
    d_q.push_back(mk(32'h1000_0008, 1'b1, 1'b0, n + 15));
    wait_cyc(n + 15);
    i_req = 1'b0; d_req = 1'b0;

    // Reset during CAPTURE of a load: no completion, fetch then wins re-arbitration.
    @(negedge clk);
    n = cyc;
    d_we = 1'b0; d_addr = 32'd40; d_req = 1'b1;
    wait_cyc(n + 2);
    rst = 1'b1; i_addr = 32'd4; i_req = 1'b1;
    wait_cyc(n + 3);
    chk("rst_cap_no_ready", {31'd0, d_ready}, 32'd0);
    chk("rst_cap_r_wbar", {31'd0, mem_r_wbar}, 32'd1);
    rst = 1'b0;
    i_q.push_back(mk(32'h1000_0004, 1'b1, 1'b0, n + 6));
    d_q.push_back(mk(32'h1000_0028, 1'b1, 1'b0, n + 10));
    wait_cyc(n + 6);
    i_req = 1'b0;
    wait_cyc(n + 10);
    d_req = 1'b0;

    // Reset during ACCESS of a store: write still commits, no completion.
    @(negedge clk);
    n = cyc;
    d_we = 1'b1; d_addr = 32'd24; d_wdata = 32'd5; d_req = 1'b1;
    wait_cyc(n + 1);
    rst = 1'b1;
    wait_cyc(n + 2);
    rst = 1'b0; d_req = 1'b0;
    chk("rst_acc_no_ready", {31'd0, d_ready}, 32'd0);
    chk("rst_acc_mem24", mem[24], 32'd5);
    data(1'b0, 32'd24, 32'd0, 32'd5, 1'b1, 1'b0, 3);

    repeat (4) @(negedge clk);
    chk("i_queue_empty", i_q.size(), 32'd0);
    chk("d_queue_empty", d_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
